// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Stall vector bit order is PC/IF_ID/ID_EX/EX_MEM, and flush vector bit order is IF_ID/ID_EX/EX_MEM/MEM_WB, both MSB first.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IWAIT = 2'd1,
        ST_DIV   = 2'd2
    } state_t;

    typedef logic [3:0] stall_vec_t;
    typedef logic [3:0] flush_vec_t;

    localparam stall_vec_t STALL_NONE  = 4'b0000;
    localparam stall_vec_t STALL_FRONT = 4'b1100;
    localparam stall_vec_t STALL_DIV   = 4'b1110;
    localparam stall_vec_t STALL_ALL   = 4'b1111;

    localparam flush_vec_t FLUSH_NONE   = 4'b0000;
    localparam flush_vec_t FLUSH_IF_ID  = 4'b1000;
    localparam flush_vec_t FLUSH_ID_EX  = 4'b0100;
    localparam flush_vec_t FLUSH_EX_MEM = 4'b0010;
    localparam flush_vec_t FLUSH_MEM_WB = 4'b0001;

    // A load writing $0 never creates a dependency.
    function automatic logic load_use(input logic       memread,
                                      input logic [4:0] wa,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       uses_rt);
        return memread && (wa != 5'd0) &&
               ((rs == wa) || (uses_rt && (rt == wa)));
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running stall-cycle and flush-cycle counters for the pipeline sequencer.
// Instantiated only when PIPE_CTRL_PERF_EN is defined; both counters wrap.
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_stall_cyc <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (stall_inc) perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (flush_inc) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: D-cache freeze, divider, I-cache wait, load-use and branch.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] IF_ID_rs,
    input  logic [4:0] IF_ID_rt,
    input  logic       ID_uses_rt,
    input  logic       ID_EX_memread,
    input  logic [4:0] ID_EX_WA,
    input  logic       ID_branch_taken,
    input  logic       icache_miss,
    input  logic       icache_ready,
    input  logic       dcache_req,
    input  logic       dcache_ready,
    input  logic       div_start,
    output logic       pc_stall,
    output logic       IF_ID_stall,
    output logic       ID_EX_stall,
    output logic       EX_MEM_stall,
    output logic       IF_ID_flush,
    output logic       ID_EX_flush,
    output logic       EX_MEM_flush,
    output logic       MEM_WB_flush,
    output logic       div_done,
    output logic [1:0] ctrl_state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

    state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic       i_done, i_done_n;
    logic       freeze;
    stall_vec_t stall, hz_stall;
    flush_vec_t flush, hz_flush;

    assign freeze = dcache_req && !dcache_ready;

    // Load-use beats a taken branch; the branch re-resolves once the bubble has passed.
    always_comb begin
        hz_stall = STALL_NONE;
        hz_flush = FLUSH_NONE;
        if (load_use(ID_EX_memread, ID_EX_WA, IF_ID_rs, IF_ID_rt, ID_uses_rt)) begin
            hz_stall = STALL_FRONT;
            hz_flush = FLUSH_ID_EX;
        end else if (ID_branch_taken) begin
            hz_flush = FLUSH_IF_ID;
        end
    end

    always_comb begin
        stall    = STALL_NONE;
        flush    = FLUSH_NONE;
        div_done = 1'b0;
        state_n  = state;
        cnt_n    = cnt;
        i_done_n = i_done;
        if (freeze) begin
            stall = STALL_ALL;
            flush = FLUSH_MEM_WB;
            // Remember a line delivered while frozen so IWAIT can leave on the first free cycle.
            if (state == ST_IWAIT && icache_ready) i_done_n = 1'b1;
        end else begin
            case (state)
                ST_DIV: begin
                    if (cnt != '0) begin
                        stall = STALL_DIV;
                        flush = FLUSH_EX_MEM;
                        cnt_n = cnt - CW'(1);
                    end else begin
                        div_done = 1'b1;
                        state_n  = ST_RUN;
                    end
                end
                ST_IWAIT: begin
                    if (icache_ready || i_done) begin
                        stall    = hz_stall;
                        flush    = hz_flush;
                        state_n  = ST_RUN;
                        i_done_n = 1'b0;
                    end else begin
                        stall = STALL_FRONT;
                        flush = FLUSH_ID_EX;
                    end
                end
                default: begin
                    if (div_start) begin
                        stall   = STALL_DIV;
                        flush   = FLUSH_EX_MEM;
                        cnt_n   = CNT_LOAD;
                        state_n = ST_DIV;
                    end else if (icache_miss && !icache_ready) begin
                        stall   = STALL_FRONT;
                        flush   = FLUSH_ID_EX;
                        state_n = ST_IWAIT;
                    end else begin
                        // A miss completing in the same cycle it is seen needs no wait state.
                        stall = hz_stall;
                        flush = hz_flush;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_RUN;
            cnt    <= '0;
            i_done <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            i_done <= i_done_n;
        end
    end

    assign {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall} = stall;
    assign {IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush} = flush;
    assign ctrl_state = state;

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt u_perf (
        .clk            (clk),
        .rstn           (rstn),
        .stall_inc      (stall[3]),
        .flush_inc      (|flush),
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus randomized cache/divider traffic.
// Counter checks are added when PIPE_CTRL_PERF_EN is defined.
module tb_pipeline_ctrl;

    localparam int DIVC = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [4:0] IF_ID_rs = '0, IF_ID_rt = '0, ID_EX_WA = '0;
    logic       ID_uses_rt = 0, ID_EX_memread = 0, ID_branch_taken = 0;
    logic       icache_miss = 0, icache_ready = 0, dcache_req = 0, dcache_ready = 0, div_start = 0;
    logic       pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
    logic       IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
    logic       div_done;
    logic [1:0] ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_ctrl #(.DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rstn(rstn),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .ID_uses_rt(ID_uses_rt),
        .ID_EX_memread(ID_EX_memread), .ID_EX_WA(ID_EX_WA), .ID_branch_taken(ID_branch_taken),
        .icache_miss(icache_miss), .icache_ready(icache_ready),
        .dcache_req(dcache_req), .dcache_ready(dcache_ready), .div_start(div_start),
        .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
        .EX_MEM_stall(EX_MEM_stall), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush),
        .div_done(div_done), .ctrl_state(ctrl_state)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    typedef struct packed {
        logic pc_s, ifid_s, idex_s, exmem_s;
        logic ifid_f, idex_f, exmem_f, memwb_f;
        logic done;
        logic [1:0] st;
    } obs_t;

    typedef struct packed {
        obs_t        o;
        logic [31:0] cyc;
    } sb_t;

    typedef struct {
        logic [4:0] rs, rt, wa;
        logic uses_rt, memread, branch, imiss, irdy, dreq, drdy, dstart;
    } stim_t;

    sb_t sb_q[$];
    int  checks = 0, errors = 0, pushed = 0, popped = 0, cyc = 0;

    // Reference model: remaining divide stall cycles (-1 = no divide), waiting-for-line flag, line-seen flag.
    int  div_left = -1;
    bit  in_iwait = 0, line_seen = 0;

    function automatic obs_t sampleDut();
        return {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
                IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, div_done, ctrl_state};
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rs = '0; s.rt = '0; s.wa = '0;
        s.uses_rt = 0; s.memread = 0; s.branch = 0; s.imiss = 0;
        s.irdy = 0; s.dreq = 0; s.drdy = 0; s.dstart = 0;
        return s;
    endfunction

    task automatic checkOutput(input string name, input obs_t act, input obs_t exp, input int c);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: actual %b required %b (stalls4 flush4 done st2)",
                     name, c, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic modelStep(input stim_t s, output obs_t e);
        bit frz, lu, run_cycle;
        frz = s.dreq && !s.drdy;
        lu  = s.memread && s.wa != 0 && (s.rs == s.wa || (s.uses_rt && s.rt == s.wa));
        e = '0;
        e.st = (div_left >= 0) ? 2'd2 : (in_iwait ? 2'd1 : 2'd0);
        if (frz) begin
            {e.pc_s, e.ifid_s, e.idex_s, e.exmem_s, e.memwb_f} = 5'b11111;
            if (in_iwait && s.irdy) line_seen = 1;
        end else if (div_left > 0) begin
            {e.pc_s, e.ifid_s, e.idex_s, e.exmem_f} = 4'b1111;
            div_left--;
        end else if (div_left == 0) begin
            e.done = 1;
            div_left = -1;
        end else if (in_iwait && !(s.irdy || line_seen)) begin
            {e.pc_s, e.ifid_s, e.idex_f} = 3'b111;
        end else begin
            run_cycle = !in_iwait;
            in_iwait  = 0;
            line_seen = 0;
            if (run_cycle && s.dstart) begin
                {e.pc_s, e.ifid_s, e.idex_s, e.exmem_f} = 4'b1111;
                div_left = DIVC - 1;
            end else if (run_cycle && s.imiss && !s.irdy) begin
                {e.pc_s, e.ifid_s, e.idex_f} = 3'b111;
                in_iwait = 1;
            end else if (lu) begin
                {e.pc_s, e.ifid_s, e.idex_f} = 3'b111;
            end else if (s.branch) begin
                e.ifid_f = 1;
            end
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        obs_t e;
        @(posedge clk);
        #1;
        IF_ID_rs = s.rs; IF_ID_rt = s.rt; ID_EX_WA = s.wa; ID_uses_rt = s.uses_rt;
        ID_EX_memread = s.memread; ID_branch_taken = s.branch;
        icache_miss = s.imiss; icache_ready = s.irdy;
        dcache_req = s.dreq; dcache_ready = s.drdy; div_start = s.dstart;
        cyc++;
        modelStep(s, e);
        sb_q.push_back({e, 32'(cyc)});
        pushed++;
    endtask

    task automatic doReset(input string name);
        @(negedge clk);
        #2;
        IF_ID_rs = '0; IF_ID_rt = '0; ID_EX_WA = '0; ID_uses_rt = 0; ID_EX_memread = 0;
        ID_branch_taken = 0; icache_miss = 0; icache_ready = 0;
        dcache_req = 0; dcache_ready = 0; div_start = 0;
        rstn = 1'b0;
        #1;
        checkOutput(name, sampleDut(), '0, cyc);
`ifdef PIPE_CTRL_PERF_EN
        checkCount({name, "_perf_stall"}, perf_stall_cyc, 32'd0);
        checkCount({name, "_perf_flush"}, perf_flush_cnt, 32'd0);
`endif
        div_left = -1; in_iwait = 0; line_seen = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents a decision; compare it with the oldest expectation.
    always @(negedge clk) begin
        sb_t ent;
        if (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            popped++;
            checkOutput("scoreboard", sampleDut(), ent.o, int'(ent.cyc));
        end
    end

    initial begin
        stim_t s;
        int ic_left, dc_left;
`ifdef PIPE_CTRL_PERF_EN
        logic [31:0] st0, fl0;
`endif
        doReset("reset_initial");

        // Load-use on rs, then the same with destination $0.
        s = idle(); s.memread = 1; s.wa = 5; s.rs = 5; applyStimulus(s);
        s.wa = 0; applyStimulus(s);
        // Load-use through rt only when rt is actually read.
        s = idle(); s.memread = 1; s.wa = 7; s.rt = 7; s.uses_rt = 1; applyStimulus(s);
        s.uses_rt = 0; applyStimulus(s);
        // Taken branch alone, then together with a load-use, then alone again.
        s = idle(); s.branch = 1; applyStimulus(s);
        s.memread = 1; s.wa = 3; s.rs = 3; applyStimulus(s);
        s.memread = 0; applyStimulus(s);

        // Plain divide.
        s = idle(); s.dstart = 1; applyStimulus(s);
        repeat (DIVC + 1) applyStimulus(idle());
        // Divide frozen for three cycles at cnt=2.
        s = idle(); s.dstart = 1; applyStimulus(s);
        applyStimulus(idle());
        s = idle(); s.dreq = 1; repeat (3) applyStimulus(s);
        s.drdy = 1; applyStimulus(s);
        repeat (3) applyStimulus(idle());

        // I-cache miss for five cycles with a branch held in ID.
        s = idle(); s.imiss = 1; s.branch = 1; repeat (4) applyStimulus(s);
        s.irdy = 1; applyStimulus(s);
        applyStimulus(idle());
        // Line delivered while frozen in IWAIT.
        s = idle(); s.imiss = 1; repeat (2) applyStimulus(s);
        s.dreq = 1; applyStimulus(s);
        s.irdy = 1; applyStimulus(s);
        s = idle(); s.dreq = 1; applyStimulus(s);
        s.drdy = 1; applyStimulus(s);
        repeat (2) applyStimulus(idle());

`ifdef PIPE_CTRL_PERF_EN
        doReset("reset_before_perf");
        applyStimulus(idle());
        st0 = perf_stall_cyc; fl0 = perf_flush_cnt;
        s = idle(); s.dstart = 1; applyStimulus(s);
        repeat (DIVC) applyStimulus(idle());
        applyStimulus(idle());
        checkCount("perf_stall_divide", perf_stall_cyc - st0, 32'(DIVC));
        checkCount("perf_flush_divide", perf_flush_cnt - fl0, 32'(DIVC));
`endif

        // Asynchronous reset in the middle of a divide and of an I-cache wait.
        s = idle(); s.dstart = 1; applyStimulus(s);
        repeat (2) applyStimulus(idle());
        doReset("reset_mid_div");
        s = idle(); s.imiss = 1; repeat (3) applyStimulus(s);
        doReset("reset_mid_iwait");

        ic_left = 0; dc_left = 0;
        repeat (3000) begin
            s = idle();
            if (ic_left == 0 && $urandom_range(0, 7) == 0) ic_left = int'($urandom_range(1, 6));
            if (ic_left > 0) begin
                s.imiss = 1; s.irdy = (ic_left == 1); ic_left--;
            end
            if (dc_left == 0 && $urandom_range(0, 5) == 0) dc_left = int'($urandom_range(1, 4));
            if (dc_left > 0) begin
                s.dreq = 1; s.drdy = (dc_left == 1); dc_left--;
            end
            s.dstart  = ($urandom_range(0, 9) == 0);
            s.memread = ($urandom_range(0, 2) == 0);
            s.wa      = 5'($urandom_range(0, 3));
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.uses_rt = 1'($urandom_range(0, 1));
            s.branch  = ($urandom_range(0, 3) == 0);
            applyStimulus(s);
        end

        @(negedge clk);
        #1;
        checkCount("scoreboard_drain", popped, pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
